// File: rtl/firebird_muldiv_unit.sv
// firebird_muldiv_unit: iterative RV32M mul/div (clk, rst, in_valid/in_ready/funct3/operand_a/operand_b in, out_valid/out_ready/result out, kill with FIREBIRD_MULDIV_KILL_EN)
module firebird_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
`ifdef FIREBIRD_MULDIV_KILL_EN
  ,
  input  logic            kill
`endif
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3;
  logic neg, abort;
  logic [XLEN-1:0] m, hi, lo, hi_n, lo_n, r_sub, div_w, div_s, final_w, ma_in, mb_in, spec_res;
  logic [XLEN:0] mul_sum, r_sh;
  logic [2*XLEN-1:0] prod, prod_s;
  logic sa, sb, ge, div_zero, div_ovf, special, accept;
`ifdef FIREBIRD_MULDIV_KILL_EN
  assign abort = kill;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    sa = operand_a[XLEN-1] & (funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]));
    sb = operand_b[XLEN-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
    ma_in = sa ? -operand_a : operand_a;
    mb_in = sb ? -operand_b : operand_b;
    div_zero = funct3[2] & (operand_b == '0);
    div_ovf = funct3[2] & ~funct3[0] & (operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (&operand_b);
    special = div_zero | div_ovf;
    spec_res = div_zero ? (funct3[1] ? operand_a : '1) : (funct3[1] ? '0 : operand_a);
    accept = in_valid & in_ready & ~abort;
    mul_sum = {1'b0, hi} + {1'b0, lo[0] ? m : '0};
    r_sh = {hi, lo[XLEN-1]};
    ge = r_sh >= {1'b0, m};
    r_sub = r_sh[XLEN-1:0] - m;
    hi_n = f3[2] ? (ge ? r_sub : r_sh[XLEN-1:0]) : mul_sum[XLEN:1];
    lo_n = f3[2] ? {lo[XLEN-2:0], ge} : {mul_sum[0], lo[XLEN-1:1]};
    prod = {hi_n, lo_n};
    prod_s = neg ? -prod : prod;
    div_w = f3[1] ? hi_n : lo_n;
    div_s = neg ? -div_w : div_w;
    final_w = f3[2] ? div_s : (f3[1:0] == 2'd0 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (special ? DONE : CALC) : IDLE;
      CALC: state_n = abort ? IDLE : (cnt == CNT_W'(1) ? DONE : CALC);
      default: state_n = (out_ready | abort) ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      neg <= 1'b0;
      m <= '0;
      hi <= '0;
      lo <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        f3 <= funct3;
        neg <= (funct3[2] & funct3[1]) ? sa : sa ^ sb;
        m <= funct3[2] ? mb_in : ma_in;
        lo <= funct3[2] ? ma_in : mb_in;
        hi <= '0;
        cnt <= CNT_W'(XLEN);
        if (special) result <= spec_res;
      end else if (state == CALC && !abort) begin
        hi <= hi_n;
        lo <= lo_n;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) result <= final_w;
      end
    end
  end
endmodule

// File: tb/tb_firebird_muldiv_unit.sv
// tb_firebird_muldiv_unit: directed self-checking bench for firebird_muldiv_unit
module tb_firebird_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [2:0] funct3 = '0;
  logic [31:0] operand_a = '0, operand_b = '0, result, held;
  int checks = 0, fails = 0, lat, pulses;
`ifdef FIREBIRD_MULDIV_KILL_EN
  logic kill = 1'b0;
`endif
  always #5 clk = ~clk;
  firebird_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
`ifdef FIREBIRD_MULDIV_KILL_EN
    , .kill(kill)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f;
    operand_a = a;
    operand_b = b;
    in_valid = 1'b1;
    chk("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {30'b0, in_ready, out_valid}, 32'b10);
  endtask
  task automatic op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int exp_lat);
    issue(f, a, b);
    wait_out(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk(tag, result, exp);
    drain(tag);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {result[29:0], in_ready, out_valid}, 32'b10);
    rst = 1'b0;
    op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    op("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    op("mul_small", 3'd0, 32'd12345, 32'd1000, 32'd12345000, 33);
    issue(3'd5, 32'd100, 32'd7);
    wait_out(lat);
    held = result;
    chk("bp_result", held, 32'd14);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_stable", {result[29:0], in_ready, out_valid}, {held[29:0], 2'b01});
    end
    drain("bp");
    op("back_to_back", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    issue(3'd0, 32'd3, 32'd5);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_calc", {result[29:0], in_ready, out_valid}, 32'b10);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("rst_no_pulse", pulses, 0);
    op("after_rst", 3'd0, 32'd3, 32'd5, 32'd15, 33);
`ifdef FIREBIRD_MULDIV_KILL_EN
    issue(3'd0, 32'd3, 32'd5);
    repeat (11) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    chk("kill_mid_calc", {30'b0, in_ready, out_valid}, 32'b10);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("kill_no_pulse", pulses, 0);
    op("after_kill", 3'd3, 32'd6, 32'd7, 32'd0, 33);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
